// File: rtl/alu_result_stage.sv
// Result capture stage behind alu_32: a 2-entry FIFO that normalises flags per opcode,
// plus sticky overflow/illegal flags and a count of accepted results.
module alu_result_stage #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_ovf,
  input  logic [3:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  input  logic             clear_sticky,
  output logic             sticky_ovf,
  output logic             sticky_illegal,
  output logic [15:0]      op_count
);

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;
  localparam logic [3:0] SEL_EQ  = 4'b1111;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  logic             push;
  logic             pop;
  logic             new_illegal;
  logic             new_ovf;
  logic             new_carry;
  logic             new_zero;
  logic [3:0]       new_flags;
  logic [31:0]      tail_result;
  logic [TAG_W-1:0] tail_tag;
  logic [3:0]       tail_flags;
  logic             unused_in_zero;

  // Zero is recomputed from the result, so the ALU's own zero flag is not consumed.
  assign unused_in_zero = in_zero;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Flag normalisation: carry only for ADD, overflow only for ADD/SUB.
  always_comb begin
    new_illegal = 1'b1;
    new_ovf     = 1'b0;
    new_carry   = 1'b0;
    new_zero    = (in_result == 32'h0);
    case (in_sel)
      SEL_AND, SEL_OR, SEL_SLT, SEL_NOR, SEL_EQ: new_illegal = 1'b0;
      SEL_ADD: begin
        new_illegal = 1'b0;
        new_carry   = in_carry;
        new_ovf     = in_ovf;
      end
      SEL_SUB: begin
        new_illegal = 1'b0;
        new_ovf     = in_ovf;
      end
      default: new_illegal = 1'b1;
    endcase
    new_flags = {new_illegal, new_ovf, new_carry, new_zero};
  end

  // Occupancy FSM; head entry lives directly in the out_* registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      out_result  <= 32'h0;
      out_tag     <= '0;
      out_flags   <= 4'h0;
      tail_result <= 32'h0;
      tail_tag    <= '0;
      tail_flags  <= 4'h0;
    end else begin
      case (state)
        EMPTY: if (push) begin
          out_result <= in_result;
          out_tag    <= in_tag;
          out_flags  <= new_flags;
          out_valid  <= 1'b1;
          state      <= ONE;
        end
        ONE: begin
          if (push && pop) begin
            out_result <= in_result;
            out_tag    <= in_tag;
            out_flags  <= new_flags;
          end else if (push) begin
            tail_result <= in_result;
            tail_tag    <= in_tag;
            tail_flags  <= new_flags;
            in_ready    <= 1'b0;
            state       <= FULL;
          end else if (pop) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: if (pop) begin
          out_result <= tail_result;
          out_tag    <= tail_tag;
          out_flags  <= tail_flags;
          in_ready   <= 1'b1;
          state      <= ONE;
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

  // A same-cycle set beats clear_sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf     <= 1'b0;
      sticky_illegal <= 1'b0;
      op_count       <= 16'h0;
    end else begin
      sticky_ovf     <= (sticky_ovf && !clear_sticky) || (push && new_ovf);
      sticky_illegal <= (sticky_illegal && !clear_sticky) || (push && new_illegal);
      if (push) op_count <= op_count + 16'(1);
    end
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter TAG_W, default 5, width of the destination tag carried with each result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  ALU result presented this cycle.
REQ-005 in_ready  output  1  stage can accept a result; registered, no combinational path from out_ready.
REQ-006 in_result  input  32  ALU_Out value from alu_32.
REQ-007 in_carry, in_zero, in_ovf  input  1 each  Carry_Out, Zero, Overflow from alu_32.
REQ-008 in_sel  input  4  ALU_Sel code that produced the result.
REQ-009 in_tag  input  TAG_W  destination tag.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  consumer takes head entry.
REQ-012 out_result  output  32  head result.
REQ-013 out_tag  output  TAG_W  head tag.
REQ-014 out_flags  output  4  head flags {illegal, ovf, carry, zero}.
REQ-015 clear_sticky  input  1  synchronous clear of sticky flags.
REQ-016 sticky_ovf, sticky_illegal  output  1 each  accumulated flags since last clear/reset.
REQ-017 op_count  output  16  number of accepted results, wraps 16'hFFFF -> 0.

Function
REQ-018 Storage SHALL be a 2-entry FIFO; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-019 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL.
REQ-021 Transitions: EMPTY+push -> ONE; ONE+push-only -> FULL; ONE+pop-only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE; no other event changes state.
REQ-022 out_valid SHALL be 1 exactly when state is not EMPTY; out_* SHALL show the oldest entry; order SHALL be preserved.
REQ-023 Latency: result pushed at edge N SHALL be visible on out_* after edge N (out_valid high in cycle N+1) when FIFO was EMPTY.
REQ-024 Head outputs SHALL hold stable while out_valid && !out_ready.
REQ-025 Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1111 EQ; any other in_sel SHALL set stored illegal=1.
REQ-026 Stored carry SHALL equal in_carry for ADD, else 0.
REQ-027 Stored ovf SHALL equal in_ovf for ADD or SUB, else 0.
REQ-028 Stored zero SHALL be recomputed as (in_result == 32'h0), ignoring in_zero.
REQ-029 in_result and in_tag SHALL be stored unmodified, including for illegal codes.
REQ-030 On push, sticky_ovf |= stored ovf and sticky_illegal |= stored illegal, visible next cycle.
REQ-031 clear_sticky SHALL clear both sticky flags; if a push with ovf/illegal occurs the same cycle, the set SHALL win.
REQ-032 op_count SHALL increment by 1 per push, independent of pops and clear_sticky.
REQ-033 Inputs with in_valid=0 SHALL have no effect on any state.

Reset
REQ-034 rst SHALL immediately force state EMPTY, out_valid=0, in_ready=1, sticky flags 0, op_count 0, out_result 0, out_tag 0, out_flags 0.
REQ-035 rst asserted mid-operation SHALL discard all stored entries; no entry SHALL emerge after release.
REQ-036 First push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-037 ADD: in_sel=0010, in_result=32'h0, in_carry=1, in_ovf=0, tag=3, out_ready=1 -> next cycle out_valid=1, out_tag=3, out_flags=4'b0011, op_count=1.
REQ-038 Backpressure: out_ready=0, push tags 1,2,3 on consecutive cycles -> tags 1,2 stored, in_ready=0 after second push, tag 3 not accepted; raise out_ready -> outputs tag 1 then tag 2.
REQ-039 Masking: AND with in_carry=1, in_ovf=1, in_result=32'h5 -> out_flags=4'b0000, sticky_ovf stays 0.
REQ-040 Illegal: in_sel=0011, in_result=32'hDEADBEEF -> out_flags[3]=1, out_result=32'hDEADBEEF, sticky_illegal=1; clear_sticky pulse -> 0.
REQ-041 Simultaneous: state ONE, push and pop same cycle -> state ONE, new entry at head next cycle; clear_sticky with SUB in_ovf=1 same cycle -> sticky_ovf=1.
REQ-042 Reset mid-flight: state FULL, assert rst asynchronously -> out_valid=0, in_ready=1, op_count=0 without a clock edge.
